// File: rtl/updi_pkg.sv
// UPDI protocol constants, program block types and the shared state/error
// enumerations used by the program block writer.
package updi_pkg;

    // UPDI opcodes and the ACK byte returned by the target
    localparam logic [7:0] UPDI_SYNC        = 8'h55;
    localparam logic [7:0] UPDI_ST_PTR16    = 8'h69;
    localparam logic [7:0] UPDI_REPEAT      = 8'hA0;
    localparam logic [7:0] UPDI_ST_PTR_INC8 = 8'h64;
    localparam logic [7:0] UPDI_ACK         = 8'h40;

    // Block types produced by the program decoder
    localparam logic [7:0] BLK_TYPE_DATA = 8'h00;
    localparam logic [7:0] BLK_TYPE_EOF  = 8'h01;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DECODE,
        S_SEND,
        S_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_MISMATCH = 2'd2
    } err_code_t;

endpackage

// File: rtl/updi_ack_waiter.sv
// ACK checker for the program block writer: while armed, reports the first
// received byte as ok (UPDI ACK) or fail (mismatch), or fails once the
// timeout expires. Present only when PROGRAM_BLOCK_WRITER_ACK_CHECK_EN is defined.
`ifdef PROGRAM_BLOCK_WRITER_ACK_CHECK_EN
module updi_ack_waiter
    import updi_pkg::*;
#(
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       ok,
    output logic       fail,
    output err_code_t  code
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    logic [TW-1:0] cnt;
    logic          timed_out;

    // Cycles spent armed; restarts from zero whenever the writer leaves ACK
    always_ff @(posedge clk) begin
        if (!rst || !arm) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

    assign timed_out = (cnt == TW'(ACK_TIMEOUT - 1));

    // Verdict for the current cycle; a received byte takes priority over timeout
    always_comb begin
        ok   = 1'b0;
        fail = 1'b0;
        code = ERR_NONE;
        if (arm) begin
            if (rx_valid) begin
                if (rx_data == UPDI_ACK) begin
                    ok = 1'b1;
                end else begin
                    fail = 1'b1;
                    code = ERR_MISMATCH;
                end
            end else if (timed_out) begin
                fail = 1'b1;
                code = ERR_TIMEOUT;
            end
        end
    end

endmodule
`endif

// File: rtl/program_block_writer.sv
// program_block_writer: requests decoded program blocks one at a time and
// serialises each data block as SYNC/ST ptr/addr, optional REPEAT, then
// SYNC/ST *(ptr++)/data onto the UPDI transmit byte stream.
// Define PROGRAM_BLOCK_WRITER_ACK_CHECK_EN to check target ACKs on rx.
module program_block_writer
    import updi_pkg::*;
#(
    parameter int DATA_BLOCK_MAX_SIZE = 64,
    parameter int ACK_TIMEOUT         = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             go,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [1:0]                       err_code,
    output logic                             prog_start,
    input  logic                             prog_ready,
    input  logic                             prog_done,
    input  logic [7:0]                       block_length,
    input  logic [15:0]                      block_address,
    input  logic [7:0]                       block_type,
    input  logic [8*DATA_BLOCK_MAX_SIZE-1:0] block_data,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid
);

    localparam int         DIX_W   = $clog2(DATA_BLOCK_MAX_SIZE) + 1;
    localparam logic [7:0] MAX_LEN = 8'(DATA_BLOCK_MAX_SIZE);
`ifdef PROGRAM_BLOCK_WRITER_ACK_CHECK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [2:0]       idx, idx_nxt;     // position in the command sequence
    logic [DIX_W-1:0] dix, dix_nxt;     // next data byte to send
    logic             rep, rep_nxt;     // REPEAT still to be emitted
    logic             busy_nxt, done_nxt, error_nxt, prog_start_nxt, tx_valid_nxt;
    logic [1:0]       err_code_nxt;
    logic [7:0]       tx_data_nxt;
    logic [7:0]       len_eff;
    logic [7:0]       dix_ext;
    logic             last_data;
    logic             ack_ok, ack_fail;
    err_code_t        ack_code;

    // Sequence positions: 0..3 SYNC ST_PTR16 addr_lo addr_hi, 4 SYNC,
    // 5 REPEAT or ST_PTR_INC8, 6 repeat count, 7 data bytes.
    function automatic logic [7:0] data_byte(input logic [DIX_W-1:0] d,
                                             input logic [8*DATA_BLOCK_MAX_SIZE-1:0] blk);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < DATA_BLOCK_MAX_SIZE; i++) begin
            if (DIX_W'(i) == d) b = blk[i*8 +: 8];
        end
        return b;
    endfunction

    function automatic logic [7:0] seq_byte(input logic [2:0] s,
                                            input logic [DIX_W-1:0] d,
                                            input logic r);
        logic [7:0] b;
        case (s)
            3'd0, 3'd4: b = UPDI_SYNC;
            3'd1:       b = UPDI_ST_PTR16;
            3'd2:       b = block_address[7:0];
            3'd3:       b = block_address[15:8];
            3'd5:       b = r ? UPDI_REPEAT : UPDI_ST_PTR_INC8;
            3'd6:       b = len_eff - 8'd1;
            default:    b = data_byte(d, block_data);
        endcase
        return b;
    endfunction

    assign len_eff   = (block_length > MAX_LEN) ? MAX_LEN : block_length;
    assign dix_ext   = 8'(dix);
    assign last_data = ((dix_ext + 8'd1) == len_eff);

`ifdef PROGRAM_BLOCK_WRITER_ACK_CHECK_EN
    updi_ack_waiter #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_waiter (
        .clk     (clk),
        .rst     (rst),
        .arm     (state == S_ACK),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .ok      (ack_ok),
        .fail    (ack_fail),
        .code    (ack_code)
    );
`else
    logic unused_rx;
    assign unused_rx = ^{rx_data, rx_valid};
    assign ack_ok    = 1'b0;
    assign ack_fail  = 1'b0;
    assign ack_code  = ERR_NONE;
`endif

    // Next state, sequence position and registered output values
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        dix_nxt        = dix;
        rep_nxt        = rep;
        err_code_nxt   = err_code;
        prog_start_nxt = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go) begin
                    state_nxt    = S_REQ;
                    err_code_nxt = ERR_NONE;
                end
            end
            S_REQ: begin
                if (prog_ready) begin
                    prog_start_nxt = 1'b1;
                    state_nxt      = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!prog_ready) state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (prog_ready) state_nxt = prog_done ? S_DONE : S_DECODE;
            end
            S_DECODE: begin
                idx_nxt = 3'd0;
                dix_nxt = '0;
                rep_nxt = (len_eff > 8'd1);
                if (block_type == BLK_TYPE_EOF) begin
                    state_nxt = S_DONE;
                end else if (block_type == BLK_TYPE_DATA && len_eff != 8'd0) begin
                    state_nxt = S_SEND;
                end else begin
                    state_nxt = S_REQ;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    case (idx)
                        3'd3: begin
                            idx_nxt   = 3'd4;
                            state_nxt = ACK_EN ? S_ACK : S_SEND;
                        end
                        3'd5: idx_nxt = rep ? 3'd6 : 3'd7;
                        3'd6: begin
                            idx_nxt = 3'd4;
                            rep_nxt = 1'b0;
                        end
                        3'd7: begin
                            dix_nxt = dix + DIX_W'(1);
                            if (ACK_EN)         state_nxt = S_ACK;
                            else if (last_data) state_nxt = S_REQ;
                        end
                        default: idx_nxt = idx + 3'd1;
                    endcase
                end
            end
            S_ACK: begin
                if (ack_fail) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = ack_code;
                end else if (ack_ok) begin
                    state_nxt = (idx == 3'd7 && dix_ext == len_eff) ? S_REQ : S_SEND;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt     = !(state_nxt inside {S_IDLE, S_DONE, S_ERROR});
        done_nxt     = (state_nxt == S_DONE);
        error_nxt    = (state_nxt == S_ERROR);
        tx_valid_nxt = (state_nxt == S_SEND);
        tx_data_nxt  = tx_valid_nxt ? seq_byte(idx_nxt, dix_nxt, rep_nxt) : 8'h00;
    end

    // State and output registers; reset clears everything so no byte survives
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            dix        <= '0;
            rep        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'd0;
            prog_start <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            dix        <= dix_nxt;
            rep        <= rep_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            err_code   <= err_code_nxt;
            prog_start <= prog_start_nxt;
            tx_valid   <= tx_valid_nxt;
            tx_data    <= tx_data_nxt;
        end
    end

endmodule

// File: tb/tb_program_block_writer.sv
// Directed bench for program_block_writer: a small decoder model feeds blocks,
// an ACK responder answers on rx, and transmitted bytes are compared against
// the UPDI sequence expected for each block.
module tb_program_block_writer;

    localparam int MAXB = 8;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst, go;
    logic              busy, done, error, prog_start;
    logic [1:0]        err_code;
    logic              prog_ready, prog_done;
    logic [7:0]        block_length, block_type;
    logic [15:0]       block_address;
    logic [MAXB*8-1:0] block_data;
    logic [7:0]        tx_data, rx_data;
    logic              tx_valid, tx_ready, rx_valid;

    always #5 clk = ~clk;

    program_block_writer #(
        .DATA_BLOCK_MAX_SIZE(MAXB),
        .ACK_TIMEOUT        (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .prog_start   (prog_start),
        .prog_ready   (prog_ready),
        .prog_done    (prog_done),
        .block_length (block_length),
        .block_address(block_address),
        .block_type   (block_type),
        .block_data   (block_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid)
    );

    typedef struct {
        logic [7:0]        typ;
        logic [7:0]        len;
        logic [15:0]       addr;
        logic [MAXB*8-1:0] data;
    } blk_t;

    typedef struct {
        logic [7:0]        len;
        logic [15:0]       addr;
        logic [MAXB*8-1:0] data;
        bit                rnd;
        int                nbytes;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    blk_t       blk_q[$];
    logic [7:0] act_q[$];
    logic [7:0] exp_q[$];
    bit         exp_ack_q[$];
    int         dec_wait = 0;
    int         starts, start_viol, stab_viol;
    bit         ack_pending, ack_off, rand_ready, hold_prev;
    int         ack_num, bad_ack_idx;
    logic [7:0] prev_data;
    int         step_no = 0;
    int         xfer_step, end_step;
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: decoder model, stability monitor, ACK responder, tx capture
    task automatic step();
        blk_t b;
        if (dec_wait > 0) begin
            dec_wait--;
            if (dec_wait == 2) prog_ready = 1'b0;
            else if (dec_wait == 0) begin
                if (blk_q.size() > 0) begin
                    b             = blk_q.pop_front();
                    block_type    = b.typ;
                    block_length  = b.len;
                    block_address = b.addr;
                    block_data    = b.data;
                    prog_done     = 1'b0;
                end else begin
                    prog_done = 1'b1;
                end
                prog_ready = 1'b1;
            end
        end
        if (prog_start) begin
            starts++;
            if (!prog_ready || dec_wait != 0) start_viol++;
            dec_wait = 3;
        end
        if (hold_prev && (!tx_valid || tx_data !== prev_data)) stab_viol++;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        if (ack_pending) begin
            ack_pending = 1'b0;
            rx_valid    = 1'b1;
            rx_data     = (ack_num == bad_ack_idx) ? 8'h00 : 8'h40;
            ack_num++;
        end
        tx_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        hold_prev = tx_valid && !tx_ready;
        prev_data = tx_data;
        if (tx_valid && tx_ready) begin
            if (act_q.size() < exp_ack_q.size() && exp_ack_q[act_q.size()] && !ack_off)
                ack_pending = 1'b1;
            act_q.push_back(tx_data);
            xfer_step = step_no;
        end
        @(posedge clk);
        #1;
        step_no++;
    endtask

    // Expected UPDI byte stream for one data block, with ACK points marked
    task automatic build_exp(input logic [15:0] addr, input logic [7:0] len,
                             input logic [MAXB*8-1:0] data);
        int l;
        l = (int'(len) > MAXB) ? MAXB : int'(len);
        exp_q.delete();
        exp_ack_q.delete();
        exp_q = '{8'h55, 8'h69, addr[7:0], addr[15:8]};
        exp_ack_q = '{0, 0, 0, 1};
        if (l > 1) begin
            exp_q.push_back(8'h55); exp_q.push_back(8'hA0); exp_q.push_back(8'(l - 1));
            repeat (3) exp_ack_q.push_back(1'b0);
        end
        exp_q.push_back(8'h55); exp_q.push_back(8'h64);
        repeat (2) exp_ack_q.push_back(1'b0);
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(data[i*8 +: 8]);
            exp_ack_q.push_back(1'b1);
        end
    endtask

    task automatic load_data_then_eof(input logic [7:0] len, input logic [15:0] addr,
                                      input logic [MAXB*8-1:0] data);
        blk_q.delete();
        blk_q.push_back('{8'h00, len, addr, data});
        blk_q.push_back('{8'h01, 8'd0, 16'h0000, '0});
        build_exp(addr, len, data);
    endtask

    // Pulse go, check start-up latency, then run until busy drops (bounded)
    task automatic run_program(input string tag, input bit rnd, input bit noack, input int bad);
        act_q.delete();
        starts = 0; start_viol = 0; stab_viol = 0;
        ack_pending = 1'b0; ack_num = 0;
        rand_ready = rnd; ack_off = noack; bad_ack_idx = bad;
        go = 1'b1;
        step();
        go = 1'b0;
        check({tag, "_busy_lat"}, busy, 1);
        step();
        check({tag, "_start_lat"}, prog_start, 1);
        for (int c = 0; c < 3000 && busy; c++) step();
        end_step = step_no;
        check({tag, "_finished"}, busy, 0);
    endtask

    task automatic check_stream(input string tag);
        logic [7:0] a;
        check({tag, "_nbytes"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            a = (i < act_q.size()) ? act_q[i] : 8'hxx;
            check($sformatf("%s_tx%0d", tag, i), a, exp_q[i]);
        end
        check({tag, "_tx_hold"}, stab_viol, 0);
        check({tag, "_start_rules"}, start_viol, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; go = 1'b0; prog_ready = 1'b1; prog_done = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        block_length = 8'h00; block_type = 8'h00; block_address = 16'h0000; block_data = '0;
        hold_prev = 1'b0; ack_pending = 1'b0; ack_off = 1'b0; rand_ready = 1'b0;
        bad_ack_idx = -1; ack_num = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        check("rst_prog_start", prog_start, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        rst = 1'b1;
        step();

        // len, addr, data (byte i at [8i+:8]), random tx_ready, hand-counted byte total
        vecs[0] = '{8'd1,  16'h8000, 64'h0000_0000_0000_00A5, 1'b0, 7};
        vecs[1] = '{8'd4,  16'h1234, 64'h0000_0000_0403_0201, 1'b0, 13};
        vecs[2] = '{8'd4,  16'h1234, 64'h0000_0000_0403_0201, 1'b1, 13};
        vecs[3] = '{8'd10, 16'hBEEF, 64'h1716_1514_1312_1110, 1'b0, 17};
        vecs[4] = '{8'd2,  16'h0000, 64'h0000_0000_0000_5AC3, 1'b1, 11};
        vecs[5] = '{8'd8,  16'hFFFF, 64'h8877_6655_4433_2211, 1'b0, 17};

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            load_data_then_eof(vecs[v].len, vecs[v].addr, vecs[v].data);
            run_program(tag, vecs[v].rnd, 1'b0, -1);
            check({tag, "_count"}, act_q.size(), vecs[v].nbytes);
            check_stream(tag);
            check({tag, "_done"}, done, 1);
            check({tag, "_error"}, error, 0);
            check({tag, "_err_code"}, err_code, 0);
            check({tag, "_starts"}, starts, 2);
        end

        // Unknown type, then an empty data block, then the decoder runs dry
        blk_q.delete();
        blk_q.push_back('{8'h07, 8'd3, 16'h4000, 64'h0000_0000_0033_2211});
        blk_q.push_back('{8'h00, 8'd0, 16'h4000, '0});
        exp_q.delete(); exp_ack_q.delete();
        run_program("skip", 1'b0, 1'b0, -1);
        check("skip_nbytes", act_q.size(), 0);
        check("skip_starts", starts, 3);
        check("skip_done", done, 1);
        check("skip_error", error, 0);

        // Reset in the middle of sending a block
        load_data_then_eof(8'd4, 16'h1234, 64'h0000_0000_0403_0201);
        act_q.delete(); ack_off = 1'b0; rand_ready = 1'b0; bad_ack_idx = -1;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 0; c < 500 && act_q.size() < 2; c++) step();
        check("mid_send_reached", (act_q.size() >= 2 && tx_valid), 1);
        rst = 1'b0; rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_error", error, 0);
        check("mrst_err_code", err_code, 0);
        check("mrst_prog_start", prog_start, 0);
        check("mrst_tx_valid", tx_valid, 0);
        check("mrst_tx_data", tx_data, 0);
        rst = 1'b1;
        dec_wait = 0; prog_ready = 1'b1; prog_done = 1'b0; blk_q.delete();
        hold_prev = 1'b0; ack_pending = 1'b0;
        step(); step();
        check("mrst_stays_idle", {busy, tx_valid}, 0);

`ifdef PROGRAM_BLOCK_WRITER_ACK_CHECK_EN
        // Wrong byte returned as the first data ACK
        load_data_then_eof(8'd1, 16'h8000, 64'hA5);
        run_program("mism", 1'b0, 1'b0, 1);
        check("mism_error", error, 1);
        check("mism_err_code", err_code, 2);
        check("mism_busy", busy, 0);
        check("mism_done", done, 0);
        check_stream("mism");
        load_data_then_eof(8'd1, 16'h8000, 64'hA5);
        run_program("recov", 1'b0, 1'b0, -1);
        check("recov_error", error, 0);
        check("recov_err_code", err_code, 0);
        check("recov_done", done, 1);

        // No ACK at all: timeout after TMO cycles in ACK
        load_data_then_eof(8'd1, 16'h8000, 64'hA5);
        run_program("tmo", 1'b0, 1'b1, -1);
        check("tmo_error", error, 1);
        check("tmo_err_code", err_code, 1);
        check("tmo_nbytes", act_q.size(), 4);
        check("tmo_ack_cycles", end_step - xfer_step - 1, TMO);
`else
        // Without ACK checking a silent target still completes the program
        load_data_then_eof(8'd1, 16'h8000, 64'hA5);
        run_program("noack", 1'b0, 1'b1, -1);
        check_stream("noack");
        check("noack_done", done, 1);
        check("noack_error", error, 0);
        check("noack_err_code", err_code, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
